// File: rtl/gsim_result_sink.sv
// -----------------------------------------------------------------------------
// gsim_result_sink
//
// Purpose:
//    Captures one solved frame of DEPTH signed Q16.16 words from the GSIM
//    solver's x_out/out_valid stream into a local buffer at full rate (GSIM has
//    no backpressure). It then drains the frame to a consumer over a
//    valid/ready handshake, tagging each word with its index and a last flag.
//
// Ports:
//    clk         in   1       clock, rising edge
//    rst_in      in   1       reset, asynchronous, active-high
//    in_valid    in   1       GSIM out_valid; one word per cycle while high
//    in_data     in   DATA_W  GSIM x_out
//    out_valid   out  1       drain word available
//    out_ready   in   1       consumer accepts word
//    out_data    out  DATA_W  drained word
//    out_index   out  IDX_W   position of out_data within the frame
//    out_last    out  1       out_data is word DEPTH-1
//    busy        out  1       not idle
//    frame_done  out  1       one-cycle pulse after the last word transfers
//    overflow    out  1       sticky; an input word arrived during drain and
//                             was dropped
//
// Build option:
//    GSIM_SINK_ROUND_EN  when defined, each word is rounded half-up to an
//                        integer at capture time (kept in Q16.16, fraction
//                        zeroed, saturating at 32'h7FFF_0000). When undefined
//                        the data path is bit-exact pass-through. Ports and
//                        timing are the same in both builds.
//
// FSM states:
//    state   | meaning
//    S_IDLE  | waiting for word 0 of a new frame
//    S_FILL  | capturing words 1..DEPTH-1; gaps in in_valid just stall
//    S_DRAIN | presenting buf[rd_ptr] to the consumer; input words dropped
// -----------------------------------------------------------------------------
module gsim_result_sink #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16,
   parameter int IDX_W  = 4
) (
   input  logic              clk,
   input  logic              rst_in,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [IDX_W-1:0]  out_index,
   output logic              out_last,
   output logic              busy,
   output logic              frame_done,
   output logic              overflow
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   state_t              state;
   state_t              state_nxt;

   logic [DATA_W-1:0]   mem [DEPTH];
   logic [IDX_W-1:0]    wr_ptr;
   logic [IDX_W-1:0]    rd_ptr;
   logic [IDX_W-1:0]    rd_ptr_inc;
   logic [DATA_W-1:0]   out_data_q;
   logic                frame_done_q;
   logic                overflow_q;

   logic [DATA_W-1:0]   wdata;
   logic                wr_en;
   logic                fill_last;
   logic                xfer;
   logic                last_xfer;
   logic                drop;

   // ---------------------------------------------------------------------------
   // Capture-time data conditioning
   // ---------------------------------------------------------------------------
`ifdef GSIM_SINK_ROUND_EN
   localparam int HI_W = DATA_W - 16;

   // Half-up rounding on the integer part. Negative .5 values therefore move
   // toward +inf (-2.5 -> -2). Only the largest positive integer part can
   // overflow when incremented, so that single case saturates.
   function automatic logic [DATA_W-1:0] round_q16(input logic [DATA_W-1:0] x);
      logic [HI_W-1:0] hi;
      hi = x[DATA_W-1:16];
      if (x[15] && (hi == {1'b0, {(HI_W-1){1'b1}}})) begin
         round_q16 = {hi, 16'h0000};
      end else begin
         round_q16 = {hi + HI_W'(x[15]), 16'h0000};
      end
   endfunction

   assign wdata = round_q16(in_data);
`else
   assign wdata = in_data;
`endif

   // ---------------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst_in) begin
      if (rst_in) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      wr_en     = 1'b0;
      xfer      = 1'b0;
      drop      = 1'b0;
      case (state)
         S_IDLE: begin
            if (in_valid) begin
               wr_en     = 1'b1;
               state_nxt = (DEPTH == 1) ? S_DRAIN : S_FILL;
            end
         end
         S_FILL: begin
            if (in_valid) begin
               wr_en = 1'b1;
               if (wr_ptr == LAST_IDX) begin
                  state_nxt = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            drop = in_valid;
            xfer = out_ready;
            if (out_ready && (rd_ptr == LAST_IDX)) begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // wr_ptr is always 0 in S_IDLE, so the same compare covers DEPTH==1.
   assign fill_last  = wr_en && (wr_ptr == LAST_IDX);
   assign last_xfer  = xfer && (rd_ptr == LAST_IDX);
   assign rd_ptr_inc = rd_ptr + IDX_W'(1);

   // ---------------------------------------------------------------------------
   // Frame buffer (not reset; contents only matter once a frame is complete)
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // ---------------------------------------------------------------------------
   // Pointers, registered read data and status
   // ---------------------------------------------------------------------------
   // out_data_q is loaded one cycle ahead of use: with the entry for index 0
   // when the frame completes, and with the next entry on every non-final
   // transfer. The buffer read is thus registered without adding latency, and
   // the word holds naturally while out_ready is low.
   always_ff @(posedge clk or posedge rst_in) begin
      if (rst_in) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         out_data_q   <= '0;
         frame_done_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         frame_done_q <= last_xfer;
         if (drop) begin
            overflow_q <= 1'b1;
         end
         if (wr_en) begin
            wr_ptr <= fill_last ? '0 : wr_ptr + IDX_W'(1);
         end
         if (xfer) begin
            rd_ptr <= last_xfer ? '0 : rd_ptr_inc;
         end
         if (fill_last) begin
            // With a single-word frame, entry 0 is the word being written now.
            out_data_q <= (DEPTH == 1) ? wdata : mem[0];
         end else if (xfer && !last_xfer) begin
            out_data_q <= mem[rd_ptr_inc];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign out_valid  = (state == S_DRAIN);
   assign out_data   = out_data_q;
   assign out_index  = rd_ptr;
   assign out_last   = (state == S_DRAIN) && (rd_ptr == LAST_IDX);
   assign busy       = (state != S_IDLE);
   assign frame_done = frame_done_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_gsim_result_sink.sv
// -----------------------------------------------------------------------------
// tb_gsim_result_sink
//
// Directed bench for gsim_result_sink: reset values, burst fill and drain,
// gapped fill with consumer backpressure, overflow stickiness, reset mid-drain,
// and the capture-time rounding option (GSIM_SINK_ROUND_EN).
// -----------------------------------------------------------------------------
module tb_gsim_result_sink;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 16;
   localparam int IDX_W  = 4;

   logic              clk;
   logic              rst_in;
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [IDX_W-1:0]  out_index;
   logic              out_last;
   logic              busy;
   logic              frame_done;
   logic              overflow;

   int total;
   int passed;

   gsim_result_sink #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) dut (
      .clk        (clk),
      .rst_in     (rst_in),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_index  (out_index),
      .out_last   (out_last),
      .busy       (busy),
      .frame_done (frame_done),
      .overflow   (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Advance one clock; inputs and checks happen 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_seq(input logic [31:0] base, input logic [31:0] incr);
      out_ready = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         in_valid = 1'b1;
         in_data  = base + incr * k;
         step();
      end
      in_valid = 1'b0;
      in_data  = '0;
   endtask

   task automatic drain_seq(input string tag, input logic [31:0] base,
                            input logic [31:0] incr, input int n);
      out_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         chk({tag, "_valid"}, out_valid, 1'b1);
         chk({tag, "_data"},  out_data,  base + incr * i);
         chk({tag, "_index"}, out_index, i);
         chk({tag, "_last"},  out_last,  (i == DEPTH - 1));
         step();
      end
      out_ready = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_out_valid"},  out_valid,  1'b0);
      chk({tag, "_out_data"},   out_data,   32'h0);
      chk({tag, "_out_index"},  out_index,  4'h0);
      chk({tag, "_out_last"},   out_last,   1'b0);
      chk({tag, "_busy"},       busy,       1'b0);
      chk({tag, "_frame_done"}, frame_done, 1'b0);
      chk({tag, "_overflow"},   overflow,   1'b0);
   endtask

   logic [31:0] exp_r0, exp_r1, exp_r2;
   int          idx;

   initial begin
      total     = 0;
      passed    = 0;
      rst_in    = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;

      // ---- 1: reset asserted mid-cycle ----
      #2;
      rst_in = 1'b1;
      #1;
      check_reset_outputs("t1_reset");
      step();
      step();
      rst_in = 1'b0;
      step();
      check_reset_outputs("t1_idle");

      // ---- 2: burst fill, full-rate drain ----
      out_ready = 1'b1;
      for (int k = 1; k <= DEPTH; k++) begin
         in_valid = 1'b1;
         in_data  = 32'h0001_0000 * k;
         chk("t2_no_valid_during_fill", out_valid, 1'b0);
         step();
      end
      in_valid = 1'b0;
      chk("t2_busy_drain", busy, 1'b1);
      drain_seq("t2", 32'h0001_0000, 32'h0001_0000, DEPTH);
      chk("t2_done_valid", out_valid, 1'b0);
      chk("t2_done_pulse", frame_done, 1'b1);
      chk("t2_done_busy", busy, 1'b0);
      step();
      chk("t2_done_pulse_end", frame_done, 1'b0);
      chk("t2_no_overflow", overflow, 1'b0);

      // ---- 3: gapped fill, then drain with out_ready every third cycle ----
      for (int c = 0; c < 32; c++) begin
         in_valid = (c % 2 == 0);
         in_data  = in_valid ? (32'd101 + 32'(c / 2)) << 16 : 32'h0;
         if (c == 1)  chk("t3_busy_fill", busy, 1'b1);
         if (c == 29) chk("t3_not_yet_valid", out_valid, 1'b0);
         if (c == 31) chk("t3_valid_after_last", out_valid, 1'b1);
         step();
      end
      in_valid = 1'b0;
      idx = 0;
      for (int d = 0; d < 60 && idx < DEPTH; d++) begin
         out_ready = (d % 3 == 2);
         chk("t3_valid", out_valid, 1'b1);
         chk("t3_data",  out_data,  (32'd101 + 32'(idx)) << 16);
         chk("t3_index", out_index, idx);
         chk("t3_last",  out_last,  (idx == DEPTH - 1));
         step();
         if (out_ready) idx++;
      end
      out_ready = 1'b0;
      chk("t3_drained_all", idx, DEPTH);
      chk("t3_frame_done", frame_done, 1'b1);
      chk("t3_no_overflow", overflow, 1'b0);
      step();

      // ---- 4: overflow while draining ----
      out_ready = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         in_valid = 1'b1;
         in_data  = 32'h0001_0000 * k;
         if (k == 17) chk("t4_overflow_before_drop", overflow, 1'b0);
         step();
      end
      in_valid = 1'b0;
      chk("t4_overflow_set", overflow, 1'b1);
      step();
      step();
      chk("t4_overflow_sticky", overflow, 1'b1);
      // Drain words 1..16; also present a word during the final transfer.
      out_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         chk("t4_data",  out_data,  32'h0001_0000 * (i + 1));
         chk("t4_index", out_index, i);
         if (i == DEPTH - 1) begin
            in_valid = 1'b1;
            in_data  = 32'hDEAD_0000;
         end
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk("t4_frame_done", frame_done, 1'b1);
      chk("t4_idle", busy, 1'b0);
      chk("t4_overflow_after_drain", overflow, 1'b1);

      // ---- 5: reset mid-drain after 5 transfers ----
      fill_seq(32'h0051_0000, 32'h0001_0000);
      drain_seq("t5a", 32'h0051_0000, 32'h0001_0000, 5);
      chk("t5_index_before_reset", out_index, 5);
      #3;
      rst_in = 1'b1;
      #1;
      check_reset_outputs("t5_reset");
      #2;
      rst_in = 1'b0;
      step();
      fill_seq(32'hA5A5_0000, 32'h0);
      drain_seq("t5b", 32'hA5A5_0000, 32'h0, DEPTH);
      chk("t5_frame_done", frame_done, 1'b1);

      // ---- 6: rounding option ----
`ifdef GSIM_SINK_ROUND_EN
      exp_r0 = 32'h0003_0000;
      exp_r1 = 32'hFFFE_0000;
      exp_r2 = 32'h7FFF_0000;
`else
      exp_r0 = 32'h0002_8000;
      exp_r1 = 32'hFFFD_8000;
      exp_r2 = 32'h7FFF_C000;
`endif
      for (int k = 0; k < DEPTH; k++) begin
         in_valid = 1'b1;
         case (k)
            0:       in_data = 32'h0002_8000;
            1:       in_data = 32'hFFFD_8000;
            2:       in_data = 32'h7FFF_C000;
            default: in_data = 32'h0001_0000 * k;
         endcase
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         case (i)
            0:       chk("t6_round_pos_half", out_data, exp_r0);
            1:       chk("t6_round_neg_half", out_data, exp_r1);
            2:       chk("t6_round_saturate", out_data, exp_r2);
            default: chk("t6_integer", out_data, 32'h0001_0000 * i);
         endcase
         step();
      end
      out_ready = 1'b0;
      chk("t6_frame_done", frame_done, 1'b1);
      chk("t6_no_overflow", overflow, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
